// File: rtl/conv_step_scheduler.sv
// Convolution step scheduler: walks the ocg/oy/ox/ky/kx/icg loop nest for one layer and
//   issues one PE step descriptor per cycle. First descriptor appears two cycles after start.
//   Descriptors are held stable while step_ready is low; counters advance only on handshake.
// Ports: start/abort control, latched layer geometry, busy/done/err status, step_* descriptor
//   stream (valid/ready), run_cycles/stall_cycles performance counters.
// Optional feature macro: SCHED_PERF_CNT_EN builds the performance counters; otherwise they read 0.
module conv_step_scheduler #(
    parameter int GROUP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  kernel_h,
    input  logic [3:0]  kernel_w,
    input  logic [7:0]  input_h,
    input  logic [7:0]  input_w,
    input  logic [3:0]  stride,
    input  logic [3:0]  padding,
    input  logic [7:0]  output_h,
    input  logic [7:0]  output_w,
    input  logic [7:0]  input_channels,
    input  logic [7:0]  output_channels,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        step_valid,
    input  logic        step_ready,
    output logic [3:0]  step_ocg,
    output logic [3:0]  step_icg,
    output logic [7:0]  step_oy,
    output logic [7:0]  step_ox,
    output logic [3:0]  step_ky,
    output logic [3:0]  step_kx,
    output logic [12:0] step_iy,
    output logic [12:0] step_ix,
    output logic        step_pad,
    output logic        step_first,
    output logic        step_last,
    output logic [31:0] run_cycles,
    output logic [31:0] stall_cycles
);
    localparam int GSH = $clog2(GROUP);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;
    state_t state, state_nxt;

    // Shadow copy of the geometry, frozen for the whole layer.
    logic [3:0] sh_kh, sh_kw, sh_stride, sh_pad;
    logic [7:0] sh_ih, sh_iw, sh_oh, sh_ow, sh_ic, sh_oc;

    logic [3:0] ocg, icg, ky, kx;
    logic [7:0] oy, ox;

    // Group counts: ceil(channels/GROUP); up to 16 groups, so 5 bits.
    logic [8:0] ic_sum, oc_sum;
    logic [4:0] icg_n, ocg_n, icg_lim, ocg_lim;
    assign ic_sum  = {1'b0, sh_ic} + 9'(GROUP - 1);
    assign oc_sum  = {1'b0, sh_oc} + 9'(GROUP - 1);
    assign icg_n   = 5'(ic_sum >> GSH);
    assign ocg_n   = 5'(oc_sum >> GSH);
    assign icg_lim = icg_n - 5'd1;
    assign ocg_lim = ocg_n - 5'd1;

    logic cfg_bad;
    assign cfg_bad = (sh_kh == '0) || (sh_kw == '0) || (sh_oh == '0) || (sh_ow == '0) ||
                     (sh_stride == '0) || (sh_ic == '0) || (sh_oc == '0);

    // Per-counter wrap flags and the carry chain from innermost to outermost.
    logic icg_w, kx_w, ky_w, ox_w, oy_w, ocg_w;
    logic c_kx, c_ky, c_ox, c_oy, c_ocg, last_step, hs;
    assign icg_w = ({1'b0, icg} == icg_lim);
    assign kx_w  = (kx == sh_kw - 4'd1);
    assign ky_w  = (ky == sh_kh - 4'd1);
    assign ox_w  = (ox == sh_ow - 8'd1);
    assign oy_w  = (oy == sh_oh - 8'd1);
    assign ocg_w = ({1'b0, ocg} == ocg_lim);
    assign c_kx  = icg_w;
    assign c_ky  = c_kx & kx_w;
    assign c_ox  = c_ky & ky_w;
    assign c_oy  = c_ox & ox_w;
    assign c_ocg = c_oy & oy_w;
    assign last_step = c_ocg & ocg_w;
    // Abort wins over a same-cycle handshake.
    assign hs = step_valid && step_ready && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CHECK;
            CHECK: if (abort) state_nxt = IDLE;
                   else if (cfg_bad) state_nxt = FIN;
                   else state_nxt = RUN;
            RUN:   if (abort) state_nxt = IDLE;
                   else if (hs && last_step) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state == CHECK) || (state == RUN);
        step_valid = (state == RUN);
    end

    // Shadow registers and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sh_kh, sh_kw, sh_stride, sh_pad} <= '0;
            {sh_ih, sh_iw, sh_oh, sh_ow, sh_ic, sh_oc} <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else if (state == IDLE && start) begin
            sh_kh <= kernel_h;  sh_kw <= kernel_w;
            sh_ih <= input_h;   sh_iw <= input_w;
            sh_stride <= stride; sh_pad <= padding;
            sh_oh <= output_h;  sh_ow <= output_w;
            sh_ic <= input_channels; sh_oc <= output_channels;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (state == CHECK && !abort && cfg_bad) err <= 1'b1;
            if (state != FIN && state_nxt == FIN)    done <= 1'b1;
        end
    end

    // Loop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ocg, icg, ky, kx} <= '0;
            {oy, ox} <= '0;
        end else if (state == CHECK) begin
            {ocg, icg, ky, kx} <= '0;
            {oy, ox} <= '0;
        end else if (state == RUN && hs) begin
            icg <= icg_w ? 4'd0 : icg + 4'd1;
            if (c_kx)  kx  <= kx_w  ? 4'd0 : kx  + 4'd1;
            if (c_ky)  ky  <= ky_w  ? 4'd0 : ky  + 4'd1;
            if (c_ox)  ox  <= ox_w  ? 8'd0 : ox  + 8'd1;
            if (c_oy)  oy  <= oy_w  ? 8'd0 : oy  + 8'd1;
            if (c_ocg) ocg <= ocg_w ? 4'd0 : ocg + 4'd1;
        end
    end

    // Input coordinates: 12-bit product plus tap minus padding, in 13-bit signed space.
    logic [11:0] base_y, base_x;
    logic signed [12:0] iy_c, ix_c;
    logic pad_c, in_run;
    assign base_y = 12'(oy) * 12'(sh_stride);
    assign base_x = 12'(ox) * 12'(sh_stride);
    assign iy_c = $signed({1'b0, base_y}) + $signed({9'd0, ky}) - $signed({9'd0, sh_pad});
    assign ix_c = $signed({1'b0, base_x}) + $signed({9'd0, kx}) - $signed({9'd0, sh_pad});
    assign pad_c = (iy_c < 13'sd0) || (iy_c >= $signed({5'd0, sh_ih})) ||
                   (ix_c < 13'sd0) || (ix_c >= $signed({5'd0, sh_iw}));

    // Fields read zero outside RUN so idle/reset descriptors are all-zero.
    assign in_run     = (state == RUN);
    assign step_ocg   = in_run ? ocg : '0;
    assign step_icg   = in_run ? icg : '0;
    assign step_oy    = in_run ? oy  : '0;
    assign step_ox    = in_run ? ox  : '0;
    assign step_ky    = in_run ? ky  : '0;
    assign step_kx    = in_run ? kx  : '0;
    assign step_iy    = in_run ? iy_c : '0;
    assign step_ix    = in_run ? ix_c : '0;
    assign step_pad   = in_run & pad_c;
    assign step_first = in_run & (ky == '0) & (kx == '0) & (icg == '0);
    assign step_last  = in_run & ky_w & kx_w & icg_w;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] run_q, stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= '0;
            stall_q <= '0;
        end else if (state == IDLE && start) begin
            run_q   <= '0;
            stall_q <= '0;
        end else if (state == RUN) begin
            if (run_q != '1) run_q <= run_q + 32'd1;
            if (!step_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end
    assign run_cycles   = run_q;
    assign stall_cycles = stall_q;
`else
    assign run_cycles   = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_step_scheduler.sv
module tb_conv_step_scheduler;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, step_ready = 1'b0;
    logic [3:0] kh, kw, st, pd;
    logic [7:0] ih, iw, oh, ow, ic, oc;
    logic busy, done, err, step_valid, step_pad, step_first, step_last;
    logic [3:0] step_ocg, step_icg, step_ky, step_kx;
    logic [7:0] step_oy, step_ox;
    logic [12:0] step_iy, step_ix;
    logic [31:0] run_cycles, stall_cycles;

    typedef struct packed {
        logic [3:0]  ocg;
        logic [3:0]  icg;
        logic [7:0]  oy;
        logic [7:0]  ox;
        logic [3:0]  ky;
        logic [3:0]  kx;
        logic [12:0] iy;
        logic [12:0] ix;
        logic        pad;
        logic        first;
        logic        last;
    } desc_t;

    desc_t exp_q[$];
    desc_t got[$];
    int total = 0, bad = 0;
    int stalls, run_cyc, first_valid_cyc;

    conv_step_scheduler #(.GROUP(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .kernel_h(kh), .kernel_w(kw), .input_h(ih), .input_w(iw),
        .stride(st), .padding(pd), .output_h(oh), .output_w(ow),
        .input_channels(ic), .output_channels(oc),
        .busy(busy), .done(done), .err(err),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_ocg(step_ocg), .step_icg(step_icg), .step_oy(step_oy), .step_ox(step_ox),
        .step_ky(step_ky), .step_kx(step_kx), .step_iy(step_iy), .step_ix(step_ix),
        .step_pad(step_pad), .step_first(step_first), .step_last(step_last),
        .run_cycles(run_cycles), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t sample();
        desc_t d;
        d = '{step_ocg, step_icg, step_oy, step_ox, step_ky, step_kx,
              step_iy, step_ix, step_pad, step_first, step_last};
        return d;
    endfunction

    task automatic cfg(input int a_kh, input int a_kw, input int a_ih, input int a_iw,
                       input int a_st, input int a_pd, input int a_oh, input int a_ow,
                       input int a_ic, input int a_oc);
        kh = 4'(a_kh); kw = 4'(a_kw); ih = 8'(a_ih); iw = 8'(a_iw);
        st = 4'(a_st); pd = 4'(a_pd); oh = 8'(a_oh); ow = 8'(a_ow);
        ic = 8'(a_ic); oc = 8'(a_oc);
    endtask

    // Reference loop nest: pushes every expected descriptor for the current configuration.
    task automatic gen();
        int nkh = int'(kh), nkw = int'(kw), nih = int'(ih), niw = int'(iw);
        int nst = int'(st), npd = int'(pd), noh = int'(oh), now_ = int'(ow);
        int icgn = (int'(ic) + 15) / 16, ocgn = (int'(oc) + 15) / 16;
        int iy, ix;
        desc_t d;
        exp_q.delete();
        for (int g = 0; g < ocgn; g++)
          for (int y = 0; y < noh; y++)
            for (int x = 0; x < now_; x++)
              for (int a = 0; a < nkh; a++)
                for (int b = 0; b < nkw; b++)
                  for (int c = 0; c < icgn; c++) begin
                      iy = y * nst + a - npd;
                      ix = x * nst + b - npd;
                      d.ocg = 4'(g); d.icg = 4'(c); d.oy = 8'(y); d.ox = 8'(x);
                      d.ky = 4'(a); d.kx = 4'(b); d.iy = 13'(iy); d.ix = 13'(ix);
                      d.pad = (iy < 0) || (iy >= nih) || (ix < 0) || (ix >= niw);
                      d.first = (a == 0) && (b == 0) && (c == 0);
                      d.last = (a == nkh - 1) && (b == nkw - 1) && (c == icgn - 1);
                      exp_q.push_back(d);
                  end
    endtask

    // Start pulse at cycle T; returns inside cycle T+1 (CHECK) and checks it.
    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        chk("check_busy", 64'(busy), 64'd1);
        chk("check_novalid", 64'(step_valid), 64'd0);
    endtask

    // Drains the scoreboard; optional stall percentage, early stop, and a stray start pulse.
    task automatic run_steps(input int stall_pct, input int stop_after, input int start_at);
        int hsn = 0;
        bit prev_stall = 1'b0;
        desc_t cur, held, e;
        got.delete();
        stalls = 0; run_cyc = 0; first_valid_cyc = -1;
        while (exp_q.size() > 0 && (stop_after < 0 || hsn < stop_after)) begin
            @(negedge clk);
            start = (run_cyc == start_at);
            step_ready = ($urandom_range(99) >= stall_pct);
            #1;
            cur = sample();
            if (step_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = run_cyc;
                if (prev_stall) chk("hold", 64'(cur), 64'(held));
                if (step_ready) begin
                    e = exp_q.pop_front();
                    chk($sformatf("desc%0d", hsn), 64'(cur), 64'(e));
                    got.push_back(cur);
                    hsn++;
                    prev_stall = 1'b0;
                end else begin
                    stalls++;
                    held = cur;
                    prev_stall = 1'b1;
                end
            end
            run_cyc++;
            if (run_cyc > 5000) begin
                chk("timeout", 64'd1, 64'd0);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_done();
        @(negedge clk); #1;
        chk("done_fin", 64'(done), 64'd1);
        chk("busy_fin", 64'(busy), 64'd0);
        chk("valid_fin", 64'(step_valid), 64'd0);
        @(negedge clk); #1;
        chk("done_sticky", 64'(done), 64'd1);
    endtask

    task automatic check_perf();
`ifdef SCHED_PERF_CNT_EN
        chk("run_cycles", 64'(run_cycles), 64'(run_cyc));
        chk("stall_cycles", 64'(stall_cycles), 64'(stalls));
`else
        chk("run_cycles_off", 64'(run_cycles), 64'd0);
        chk("stall_cycles_off", 64'(stall_cycles), 64'd0);
`endif
    endtask

    initial begin
        int nf, nl, np;
        cfg(3, 3, 4, 4, 1, 0, 2, 2, 16, 16);
        // Reset state
        #22; #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_valid", 64'(step_valid), 64'd0);
        chk("rst_desc", 64'(sample()), 64'd0);
        chk("rst_perf", {run_cycles, stall_cycles}, 64'd0);
        rst_n = 1'b1;

        // Basic run: 36 steps, first valid at T+2, first/last every 9 steps, no padding
        gen();
        do_start();
        run_steps(0, -1, -1);
        chk("basic_count", 64'(got.size()), 64'd36);
        chk("basic_first_valid", 64'(first_valid_cyc), 64'd0);
        nf = 0; nl = 0; np = 0;
        foreach (got[i]) begin
            nf += int'(got[i].first); nl += int'(got[i].last); np += int'(got[i].pad);
        end
        chk("basic_nfirst", 64'(nf), 64'd4);
        chk("basic_nlast", 64'(nl), 64'd4);
        chk("basic_npad", 64'(np), 64'd0);
        if (got.size() == 36) begin
            chk("basic_first9", 64'(got[9].first), 64'd1);
            chk("basic_last8", 64'(got[8].last), 64'd1);
            chk("basic_last35", 64'(got[35].last), 64'd1);
        end
        check_done();
        check_perf();

        // Channel groups, with a start pulse mid-run that must be ignored
        cfg(3, 3, 4, 4, 1, 0, 2, 2, 32, 20);
        gen();
        do_start();
        chk("start_clears_done", 64'(done), 64'd0);
        run_steps(0, -1, 20);
        chk("cg_count", 64'(got.size()), 64'd144);
        if (got.size() == 144) begin
            chk("cg_icg0", 64'(got[0].icg), 64'd0);
            chk("cg_icg1", 64'(got[1].icg), 64'd1);
            chk("cg_ocg71", 64'(got[71].ocg), 64'd0);
            chk("cg_ocg72", 64'(got[72].ocg), 64'd1);
        end
        check_done();

        // Padding
        cfg(3, 3, 4, 4, 1, 1, 4, 4, 16, 16);
        gen();
        do_start();
        run_steps(0, -1, -1);
        chk("pad_count", 64'(got.size()), 64'd144);
        if (got.size() == 144) begin
            chk("pad0_iy", 64'(got[0].iy), 64'h1FFF);
            chk("pad0_ix", 64'(got[0].ix), 64'h1FFF);
            chk("pad0_pad", 64'(got[0].pad), 64'd1);
            chk("pad49_iy", 64'(got[49].iy), 64'd1);
            chk("pad49_pad", 64'(got[49].pad), 64'd0);
            chk("pad114_iy", 64'(got[114].iy), 64'd4);
            chk("pad114_pad", 64'(got[114].pad), 64'd1);
        end
        check_done();

        // Stride 2 with random backpressure
        cfg(3, 3, 7, 7, 2, 1, 4, 4, 16, 16);
        gen();
        do_start();
        run_steps(50, -1, -1);
        chk("stride_count", 64'(got.size()), 64'd144);
        check_perf();
        check_done();

        // Illegal configuration, then a legal start clears err
        cfg(3, 3, 4, 4, 0, 0, 2, 2, 16, 16);
        do_start();
        chk("ill_err_t1", 64'(err), 64'd0);
        @(negedge clk); #1;
        chk("ill_err", 64'(err), 64'd1);
        chk("ill_done", 64'(done), 64'd1);
        chk("ill_valid", 64'(step_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("ill_novalid", 64'(step_valid), 64'd0);
        end
        cfg(3, 3, 4, 4, 1, 0, 2, 2, 16, 16);
        gen();
        do_start();
        chk("recover_err", 64'(err), 64'd0);
        run_steps(0, -1, -1);
        chk("recover_count", 64'(got.size()), 64'd36);
        check_done();

        // Abort while step 10 is presented
        gen();
        do_start();
        run_steps(0, 10, -1);
        @(negedge clk);
        abort = 1'b1; step_ready = 1'b1;
        #1;
        chk("abort_valid_before", 64'(step_valid), 64'd1);
        if (exp_q.size() > 0) chk("abort_desc10", 64'(sample()), 64'(exp_q[0]));
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_valid", 64'(step_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_err", 64'(err), 64'd0);

        // Asynchronous reset mid-run
        gen();
        do_start();
        run_steps(0, 5, -1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(step_valid), 64'd0);
        chk("arst_status", {62'd0, done, err}, 64'd0);
        chk("arst_desc", 64'(sample()), 64'd0);
        chk("arst_perf", {run_cycles, stall_cycles}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
